// File: rtl/jtag_host.sv
// JTAG initiator: runs one IR/DR scan (or a TAP reset sequence) per command and returns captured TDO.
// Optional JTAG_HOST_IDLE_EN adds cmd_idle: extra RTI TCK cycles appended after each scan.
module jtag_host #(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = $clog2(DATA_W),
  parameter int HALF_DIV = 2
) (
  input  logic              clk,
  input  logic              trst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ir,
  input  logic              cmd_tlr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
`ifdef JTAG_HOST_IDLE_EN
  input  logic [7:0]        cmd_idle,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  // state     | meaning (each TCK cycle drives the TAP toward the named state)
  // RESET_SEQ | 5x tms=1 then tms=0      IDLE    | tck low, accepting commands
  // SEL_DR/IR | tms=1                    CAPTURE | tms=0 into Capture
  // SHIFT     | enter Shift, then n-1 shift cycles with tms=0
  // EXIT1     | last shift, tms=1        UPDATE  | tms=1, then tms=0 to RTI (+ idle cycles)
  // RESP      | one-clk rsp_valid pulse
  localparam logic [3:0] RESET_SEQ = 4'd0;
  localparam logic [3:0] IDLE      = 4'd1;
  localparam logic [3:0] SEL_DR    = 4'd2;
  localparam logic [3:0] SEL_IR    = 4'd3;
  localparam logic [3:0] CAPTURE   = 4'd4;
  localparam logic [3:0] SHIFT     = 4'd5;
  localparam logic [3:0] EXIT1     = 4'd6;
  localparam logic [3:0] UPDATE    = 4'd7;
  localparam logic [3:0] RESP      = 4'd8;

  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  logic [3:0]        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [8:0]        cnt;
  logic [LEN_W-1:0]  idx;
  logic [LEN_W-1:0]  idx_m1;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cap;
  logic              ir_q;
  logic              tlr_q;
  logic [7:0]        idle_q;
  logic              accept;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;
  assign idx_m1 = idx - LEN_W'(1);

`ifdef JTAG_HOST_IDLE_EN
  always_ff @(posedge clk or posedge trst) begin
    if (trst)        idle_q <= 8'd0;
    else if (accept) idle_q <= cmd_idle;
  end
`else
  assign idle_q = 8'd0;
`endif

  always_ff @(posedge clk or posedge trst) begin
    if (trst) begin
      state     <= RESET_SEQ;
      div_cnt   <= DIV_LAST;
      cnt       <= 9'd5;
      idx       <= '0;
      len_q     <= '0;
      data_q    <= '0;
      cap       <= '0;
      ir_q      <= 1'b0;
      tlr_q     <= 1'b0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cmd_ready <= 1'b0;
          div_cnt   <= DIV_LAST;
          tlr_q     <= cmd_tlr;
          tms       <= 1'b1;
          tdi       <= 1'b0;
          if (cmd_tlr) begin
            state <= RESET_SEQ;
            cnt   <= 9'd5;
          end else begin
            state  <= SEL_DR;
            ir_q   <= cmd_ir;
            len_q  <= cmd_len;
            data_q <= cmd_data;
            cap    <= '0;
            idx    <= '0;
          end
        end
        RESP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: if (div_cnt != '0) begin
          div_cnt <= div_cnt - DIV_W'(1);
        end else begin
          div_cnt <= DIV_LAST;
          tck     <= ~tck;
          // tck falling: sample TDO for the finished cycle and set up tms/tdi for the next one
          if (tck) begin
            case (state)
              RESET_SEQ: if (cnt == 9'd0) begin
                if (tlr_q) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                end else begin
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
                end
              end else begin
                cnt <= cnt - 9'd1;
                tms <= (cnt != 9'd1);
              end
              SEL_DR: begin
                state <= ir_q ? SEL_IR : CAPTURE;
                tms   <= ir_q;
              end
              SEL_IR: begin
                state <= CAPTURE;
                tms   <= 1'b0;
              end
              CAPTURE: begin
                state <= SHIFT;
                tms   <= 1'b0;
                idx   <= '0;
              end
              SHIFT: begin
                if (idx != '0) cap[idx_m1] <= tdo;
                tdi <= data_q[idx];
                if (idx == len_q) begin
                  state <= EXIT1;
                  tms   <= 1'b1;
                end else begin
                  idx <= idx + LEN_W'(1);
                  tms <= 1'b0;
                end
              end
              EXIT1: begin
                cap[len_q] <= tdo;
                state      <= UPDATE;
                tms        <= 1'b1;
                tdi        <= 1'b0;
                cnt        <= {1'b0, idle_q} + 9'd1;
              end
              UPDATE: begin
                tms <= 1'b0;
                if (cnt == 9'd0) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_data  <= cap;
                end else begin
                  cnt <= cnt - 9'd1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: behavioural TAP partner, directed commands, response scoreboard.
module tb_jtag_host;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;

  localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SDR = 4, E1D = 5, PDR = 6, E2D = 7, UDR = 8;
  localparam int SIS = 9, CIR = 10, SIR = 11, E1I = 12, PIR = 13, E2I = 14, UIR = 15;

  logic              clk = 1'b0;
  logic              trst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_ir = 1'b0;
  logic              cmd_tlr = 1'b0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
`ifdef JTAG_HOST_IDLE_EN
  logic [7:0]        cmd_idle = 8'd0;
`endif
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              tck, tms, tdi;
  logic              tdo = 1'b0;

  jtag_host #(.DATA_W(DATA_W), .LEN_W(LEN_W), .HALF_DIV(2)) dut (
    .clk(clk), .trst(trst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_tlr(cmd_tlr), .cmd_len(cmd_len), .cmd_data(cmd_data),
`ifdef JTAG_HOST_IDLE_EN
    .cmd_idle(cmd_idle),
`endif
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  int clk_cnt = 0;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural TAP ----------------
  int          tap_st = PDR;
  logic [3:0]  tap_ir = 4'hF;
  logic [3:0]  ir_sr = 4'h0;
  logic [31:0] dr_sr = '0;
  logic [7:0]  dr8 = 8'h3C;
  logic [31:0] dr32 = 32'h1234_5678;
  int          shift_cnt = 0;

  function automatic int tap_next(input int st, input logic m);
    case (st)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SDS : RTI;
      SDS: return m ? SIS : CDR;
      CDR: return m ? E1D : SDR;
      SDR: return m ? E1D : SDR;
      E1D: return m ? UDR : PDR;
      PDR: return m ? E2D : PDR;
      E2D: return m ? UDR : SDR;
      UDR: return m ? SDS : RTI;
      SIS: return m ? TLR : CIR;
      CIR: return m ? E1I : SIR;
      SIR: return m ? E1I : SIR;
      E1I: return m ? UIR : PIR;
      PIR: return m ? E2I : PIR;
      E2I: return m ? UIR : SIR;
      default: return m ? SDS : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR: tap_ir <= 4'hF;
      CDR: dr_sr <= (tap_ir == 4'h2) ? {24'b0, dr8} : (tap_ir == 4'h3) ? dr32 : 32'b0;
      SDR: begin
        shift_cnt <= shift_cnt + 1;
        if (tap_ir == 4'h2)      dr_sr <= {24'b0, tdi, dr_sr[7:1]};
        else if (tap_ir == 4'h3) dr_sr <= {tdi, dr_sr[31:1]};
        else                     dr_sr <= {31'b0, tdi};
      end
      UDR: begin
        if (tap_ir == 4'h2) dr8 <= dr_sr[7:0];
        if (tap_ir == 4'h3) dr32 <= dr_sr;
      end
      CIR: ir_sr <= 4'b0001;
      SIR: ir_sr <= {tdi, ir_sr[3:1]};
      UIR: tap_ir <= ir_sr;
      default: ;
    endcase
    tap_st <= tap_next(tap_st, tms);
  end

  always @(negedge tck)
    tdo <= (tap_st == SDR) ? dr_sr[0] : (tap_st == SIR) ? ir_sr[0] : 1'b0;

  // ---------------- pin logs ----------------
  logic tms_log[$];
  logic tdi_log[$];
  int   tck_t[$];

  always @(posedge tck) begin
    tms_log.push_back(tms);
    tdi_log.push_back(tdi);
    tck_t.push_back(clk_cnt);
  end

  task automatic clear_logs();
    tms_log.delete();
    tdi_log.delete();
    tck_t.delete();
  endtask

  function automatic logic [63:0] pack(input logic q[$]);
    logic [63:0] v = '0;
    for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  logic [DATA_W-1:0] exp_q[$];
  int rsp_cnt = 0;
  int last_rsp_clk = -1;

  always @(negedge clk) begin
    if (!trst && rsp_valid) begin
      rsp_cnt++;
      last_rsp_clk = clk_cnt;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got rsp_valid with data %0h, expected no response", rsp_data);
      end else begin
        chk("rsp_data", 64'(rsp_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_cmd(input logic ir, input logic tlr, input logic [LEN_W-1:0] len,
                        input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp,
                        input bit push, input bit b2b);
    int n = 0;
    int acc_clk;
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_tlr   = tlr;
    cmd_len   = len;
    cmd_data  = data;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    acc_clk = clk_cnt;
    if (b2b) chk("b2b_after_rsp", 64'(acc_clk > last_rsp_clk), 64'd1);
    cmd_valid = 1'b0;
    cmd_tlr   = 1'b0;
    cmd_ir    = ~ir;
    cmd_len   = ~len;
    cmd_data  = ~data;
    clear_logs();
  endtask

  task automatic wait_rsp();
    int start = rsp_cnt;
    int n = 0;
    while (rsp_cnt == start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", 64'(rsp_cnt != start), 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 64'(cmd_ready), 64'd1);
  endtask

  task automatic check_reset_seq(input string nm);
    int per;
    per = (tck_t.size() >= 2) ? tck_t[1] - tck_t[0] : -1;
    chk({nm, "_tck_count"}, 64'(tms_log.size()), 64'd6);
    chk({nm, "_tms"}, pack(tms_log), 64'h1F);
    chk({nm, "_period"}, 64'(per), 64'd4);
    chk({nm, "_tap_rti"}, 64'(tap_st), 64'(RTI));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_pins", {59'b0, tck, tms, tdi, cmd_ready, rsp_valid}, 64'b01000);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);

    clear_logs();
    trst = 1'b0;
    wait_ready();
    check_reset_seq("rst");

    // IR scan selecting the 8-bit register
    do_cmd(1'b1, 1'b0, 5'd3, 32'h2, 32'h1, 1'b1, 1'b0);
    wait_rsp();
    chk("ir_tck_count", 64'(tms_log.size()), 64'd10);
    chk("ir_tms", pack(tms_log), 64'h183);
    chk("ir_value", 64'(tap_ir), 64'h2);
    chk("ir_tap_rti", 64'(tap_st), 64'(RTI));

    do_cmd(1'b0, 1'b0, 5'd7, 32'hA5, 32'h3C, 1'b1, 1'b0);
    wait_rsp();
    chk("dr8_tck_count", 64'(tms_log.size()), 64'd13);
    chk("dr8_tms", pack(tms_log), 64'hC01);
    chk("dr8_tdi", pack(tdi_log), 64'h528);
    chk("dr8_update", 64'(dr8), 64'hA5);

    // single-bit scan returns bit 0 of the captured 0xA5
    do_cmd(1'b0, 1'b0, 5'd0, 32'h0, 32'h1, 1'b1, 1'b0);
    wait_rsp();
    chk("dr1_tck_count", 64'(tms_log.size()), 64'd6);

    // full-width register, two scans offered back to back
    do_cmd(1'b1, 1'b0, 5'd3, 32'h3, 32'h1, 1'b1, 1'b0);
    wait_rsp();
    do_cmd(1'b0, 1'b0, 5'd31, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    do_cmd(1'b0, 1'b0, 5'd31, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    wait_rsp();
    chk("dr32_update", 64'(dr32), 64'h0);

    do_cmd(1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    wait_rsp();
    chk("tlr_tck_count", 64'(tms_log.size()), 64'd6);
    chk("tlr_tms", pack(tms_log), 64'h1F);
    chk("tlr_ir", 64'(tap_ir), 64'hF);
    chk("tlr_tap_rti", 64'(tap_st), 64'(RTI));

    // bypass delays data by one bit behind a captured 0
    do_cmd(1'b0, 1'b0, 5'd3, 32'hB, 32'h6, 1'b1, 1'b0);
    wait_rsp();

`ifdef JTAG_HOST_IDLE_EN
    cmd_idle = 8'd3;
    do_cmd(1'b0, 1'b0, 5'd0, 32'h1, 32'h0, 1'b1, 1'b0);
    cmd_idle = 8'd0;
    wait_rsp();
    chk("idle_tck_count", 64'(tms_log.size()), 64'd9);
    chk("idle_tms", pack(tms_log), 64'h19);
`endif

    // abort mid-shift: no response expected
    shift_cnt = 0;
    do_cmd(1'b0, 1'b0, 5'd7, 32'hFF, 32'h0, 1'b0, 1'b0);
    begin
      int n = 0;
      while (shift_cnt < 4 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reach_shift4", 64'(shift_cnt >= 4), 64'd1);
    end
    trst = 1'b1;
    #1;
    chk("abort_pins", {59'b0, tck, tms, tdi, cmd_ready, rsp_valid}, 64'b01000);
    repeat (4) @(negedge clk);
    clear_logs();
    trst = 1'b0;
    wait_ready();
    check_reset_seq("abort");

    do_cmd(1'b0, 1'b0, 5'd3, 32'h5, 32'hA, 1'b1, 1'b0);
    wait_rsp();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
